slot_sequencer: RTL and testbench
=================================

SLOT_SEQUENCER -- requirements
Module: slot_sequencer

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_SLOT, default 4, giving clocks spent per operator slot; legal range 1..16.
REQ-002 The block SHALL have parameter NUM_BANKS, default 2, giving the number of register banks sequenced per sample.
REQ-003 The block SHALL have parameter OPS_PER_BANK, default 18, giving operator slots per bank.
REQ-004 clk  input  1  the single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sample_clk_en  input  1  one-cycle pulse requesting one full sample sweep.
REQ-007 overrun_clr  input  1  clears the sticky overrun flag.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 slot_valid  output  1  one-cycle pulse on the first clock of each slot.
REQ-010 bank_num  output  1  current bank, 0..NUM_BANKS-1.
REQ-011 op_num  output  5  current operator within the bank, 0..OPS_PER_BANK-1.
REQ-012 ch_num  output  4  channel owning op_num, 0..8.
REQ-013 op_type  output  1  0 = modulator, 1 = carrier.
REQ-014 sample_done  output  1  one-cycle pulse ending a sweep.
REQ-015 overrun  output  1  sticky flag: a sample request arrived while not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE -> RUN on sample_clk_en; RUN -> DONE after the final cycle of slot (bank NUM_BANKS-1, op OPS_PER_BANK-1); DONE -> IDLE unconditionally after 1 cycle.
REQ-018 sample_clk_en at cycle t in IDLE SHALL give slot_valid=1 with bank 0, op 0 at cycle t+1.
REQ-019 Each slot SHALL occupy exactly CYCLES_PER_SLOT cycles; bank_num, op_num, ch_num and op_type SHALL be stable for all of them.
REQ-020 Slot order SHALL be op 0..OPS_PER_BANK-1 in bank 0, then the same in bank 1; op_num wraps to 0 when bank_num increments.
REQ-021 A sweep SHALL last NUM_BANKS*OPS_PER_BANK*CYCLES_PER_SLOT cycles in RUN; sample_done SHALL be 1 only in DONE.
REQ-022 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-023 ch_num SHALL be (op_num mod 3) + 3*(op_num div 6); op_type SHALL be (op_num div 3) mod 2.
REQ-024 sample_clk_en in RUN or DONE SHALL be dropped; the sweep in progress is not disturbed.
REQ-025 In DONE/IDLE, indices SHALL hold bank 0, op 0, ch 0, op_type 0.
REQ-026 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-027 Reset SHALL force IDLE, busy=0, slot_valid=0, sample_done=0, overrun=0, bank_num=0, op_num=0, ch_num=0, op_type=0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no sample_done; the first cycle after reset SHALL accept sample_clk_en.
REQ-029 Reset SHALL take priority over sample_clk_en and overrun_clr in the same cycle.

Configuration
REQ-030 Macro SLOT_SEQ_OVERRUN_DETECT_EN defined: overrun SHALL be set by a dropped sample_clk_en and cleared by overrun_clr; set wins when both occur in one cycle.
REQ-031 Macro SLOT_SEQ_OVERRUN_DETECT_EN undefined: overrun SHALL be tied to 0 and overrun_clr ignored; sequencing behaviour is otherwise identical.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, NUM_BANKS/OPS_PER_BANK defaults, NUM_CHANNELS_PER_BANK=9, and the op_num/bank_num/ch_num widths.
REQ-033 The op_num -> ch_num/op_type decode SHALL be one sub-module, slot_channel_decode, combinational, with its outputs registered in the parent.
REQ-034 Downstream stages SHALL delay bank_num, op_num, ch_num and op_type with the existing shift-register delay module, so this block adds no alignment delay of its own.

Verification (CYCLES_PER_SLOT=4, defaults)
REQ-035 Pulse at cycle 0 -> slot_valid at cycles 1,5,...,141 (36 pulses); sample_done at 145; busy 1..145; IDLE at 146.
REQ-036 Same sweep -> op_num 4 gives ch 1, type 1; op_num 17 gives ch 8, type 1; op_num 6 gives ch 3, type 0; bank_num becomes 1 at cycle 73.
REQ-037 Second pulse at cycle 50, macro defined -> sweep timing unchanged, overrun=1 from cycle 51; overrun_clr at 200 -> overrun=0 at 201.
REQ-038 Reset at cycle 60 of a sweep -> all outputs at reset values at cycle 61, no sample_done; pulse at 61 -> slot_valid, op 0 at 62.
REQ-039 Pulse at the DONE cycle together with overrun_clr, macro defined -> pulse dropped, overrun=1; macro undefined -> overrun stays 0.

Source files
------------

// File: rtl/slot_sequencer_pkg.sv
// Shared FSM state, default geometry and index widths for the slot sequencer.
package slot_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_BANKS         = 2;
  localparam int DEF_OPS_PER_BANK      = 18;
  localparam int NUM_CHANNELS_PER_BANK = 9;

  localparam int OP_W   = 5;
  localparam int BANK_W = 1;
  localparam int CH_W   = 4;
  localparam int CYC_W  = 4;

endpackage

// File: rtl/slot_channel_decode.sv
// Combinational operator-slot to channel/operator-type map; the parent registers its outputs.
module slot_channel_decode
  import slot_sequencer_pkg::*;
(
  input  logic [OP_W-1:0] op_num,
  output logic [CH_W-1:0] ch_num,
  output logic            op_type
);

  // Each group of six ops holds three channels: three modulators then three carriers.
  always_comb begin
    ch_num  = 4'd0;
    op_type = 1'b0;
    case (op_num)
      5'd0:    begin ch_num = 4'd0; op_type = 1'b0; end
      5'd1:    begin ch_num = 4'd1; op_type = 1'b0; end
      5'd2:    begin ch_num = 4'd2; op_type = 1'b0; end
      5'd3:    begin ch_num = 4'd0; op_type = 1'b1; end
      5'd4:    begin ch_num = 4'd1; op_type = 1'b1; end
      5'd5:    begin ch_num = 4'd2; op_type = 1'b1; end
      5'd6:    begin ch_num = 4'd3; op_type = 1'b0; end
      5'd7:    begin ch_num = 4'd4; op_type = 1'b0; end
      5'd8:    begin ch_num = 4'd5; op_type = 1'b0; end
      5'd9:    begin ch_num = 4'd3; op_type = 1'b1; end
      5'd10:   begin ch_num = 4'd4; op_type = 1'b1; end
      5'd11:   begin ch_num = 4'd5; op_type = 1'b1; end
      5'd12:   begin ch_num = 4'd6; op_type = 1'b0; end
      5'd13:   begin ch_num = 4'd7; op_type = 1'b0; end
      5'd14:   begin ch_num = 4'd8; op_type = 1'b0; end
      5'd15:   begin ch_num = 4'd6; op_type = 1'b1; end
      5'd16:   begin ch_num = 4'd7; op_type = 1'b1; end
      5'd17:   begin ch_num = 4'd8; op_type = 1'b1; end
      default: begin ch_num = 4'd0; op_type = 1'b0; end
    endcase
  end

endmodule

// File: rtl/slot_sequencer.sv
// Per-sample operator slot sequencer. Optional sticky overrun detection is
// enabled by defining SLOT_SEQ_OVERRUN_DETECT_EN.
module slot_sequencer
  import slot_sequencer_pkg::*;
#(
  parameter int CYCLES_PER_SLOT = 4,
  parameter int NUM_BANKS       = DEF_NUM_BANKS,
  parameter int OPS_PER_BANK    = DEF_OPS_PER_BANK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_clk_en,
  input  logic              overrun_clr,
  output logic              busy,
  output logic              slot_valid,
  output logic [BANK_W-1:0] bank_num,
  output logic [OP_W-1:0]   op_num,
  output logic [CH_W-1:0]   ch_num,
  output logic              op_type,
  output logic              sample_done,
  output logic              overrun
);

  localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(CYCLES_PER_SLOT - 1);
  localparam logic [OP_W-1:0]   LAST_OP   = OP_W'(OPS_PER_BANK - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  seq_state_e        state_r;
  logic [CYC_W-1:0]  cyc_r;
  logic              slot_end_s;
  logic              sweep_end_s;
  logic [OP_W-1:0]   op_nxt_s;
  logic [BANK_W-1:0] bank_nxt_s;
  logic [CH_W-1:0]   ch_nxt_s;
  logic              type_nxt_s;

  // Next slot indices; anything outside RUN parks at bank 0, op 0.
  always_comb begin
    slot_end_s  = (cyc_r == LAST_CYC);
    sweep_end_s = slot_end_s && (op_num == LAST_OP) && (bank_num == LAST_BANK);
    op_nxt_s    = {OP_W{1'b0}};
    bank_nxt_s  = {BANK_W{1'b0}};
    case (state_r)
      ST_RUN: begin
        if (!slot_end_s) begin
          op_nxt_s   = op_num;
          bank_nxt_s = bank_num;
        end else if (sweep_end_s) begin
          op_nxt_s   = {OP_W{1'b0}};
          bank_nxt_s = {BANK_W{1'b0}};
        end else if (op_num == LAST_OP) begin
          op_nxt_s   = {OP_W{1'b0}};
          bank_nxt_s = bank_num + BANK_W'(1);
        end else begin
          op_nxt_s   = op_num + OP_W'(1);
          bank_nxt_s = bank_num;
        end
      end
      default: begin
        op_nxt_s   = {OP_W{1'b0}};
        bank_nxt_s = {BANK_W{1'b0}};
      end
    endcase
  end

  slot_channel_decode u_decode (
    .op_num  (op_nxt_s),
    .ch_num  (ch_nxt_s),
    .op_type (type_nxt_s)
  );

  // Sequencing FSM; indices are registered here with no extra alignment stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cyc_r       <= {CYC_W{1'b0}};
      busy        <= 1'b0;
      slot_valid  <= 1'b0;
      sample_done <= 1'b0;
      bank_num    <= {BANK_W{1'b0}};
      op_num      <= {OP_W{1'b0}};
      ch_num      <= {CH_W{1'b0}};
      op_type     <= 1'b0;
    end else begin
      bank_num <= bank_nxt_s;
      op_num   <= op_nxt_s;
      ch_num   <= ch_nxt_s;
      op_type  <= type_nxt_s;
      case (state_r)
        ST_IDLE: begin
          cyc_r       <= {CYC_W{1'b0}};
          sample_done <= 1'b0;
          if (sample_clk_en) begin
            state_r    <= ST_RUN;
            busy       <= 1'b1;
            slot_valid <= 1'b1;
          end else begin
            busy       <= 1'b0;
            slot_valid <= 1'b0;
          end
        end
        ST_RUN: begin
          busy <= 1'b1;
          if (!slot_end_s) begin
            cyc_r       <= cyc_r + CYC_W'(1);
            slot_valid  <= 1'b0;
            sample_done <= 1'b0;
          end else if (sweep_end_s) begin
            state_r     <= ST_DONE;
            cyc_r       <= {CYC_W{1'b0}};
            slot_valid  <= 1'b0;
            sample_done <= 1'b1;
          end else begin
            cyc_r       <= {CYC_W{1'b0}};
            slot_valid  <= 1'b1;
            sample_done <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          cyc_r       <= {CYC_W{1'b0}};
          busy        <= 1'b0;
          slot_valid  <= 1'b0;
          sample_done <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          cyc_r       <= {CYC_W{1'b0}};
          busy        <= 1'b0;
          slot_valid  <= 1'b0;
          sample_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef SLOT_SEQ_OVERRUN_DETECT_EN
  logic drop_s;

  // A request is dropped whenever the sequencer is not idle.
  always_comb begin
    drop_s = sample_clk_en && (state_r != ST_IDLE);
  end

  // Sticky overrun flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop_s) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end
`else
  logic overrun_clr_unused_s;
  assign overrun_clr_unused_s = overrun_clr;

  // Overrun detection compiled out; flag held low.
  always_ff @(posedge clk) begin
    overrun <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_slot_sequencer.sv
// Directed bench for slot_sequencer with a per-cycle sweep-timeline model.
module tb_slot_sequencer;

  localparam int CPS   = 4;
  localparam int NB    = 2;
  localparam int OPB   = 18;
  localparam int SWEEP = NB * OPB * CPS;

`ifdef SLOT_SEQ_OVERRUN_DETECT_EN
  localparam int OVR_EN = 1;
`else
  localparam int OVR_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_clk_en;
  logic       overrun_clr;
  logic       busy;
  logic       slot_valid;
  logic [0:0] bank_num;
  logic [4:0] op_num;
  logic [3:0] ch_num;
  logic       op_type;
  logic       sample_done;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  slot_sequencer #(
    .CYCLES_PER_SLOT (CPS),
    .NUM_BANKS       (NB),
    .OPS_PER_BANK    (OPB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_clk_en (sample_clk_en),
    .overrun_clr   (overrun_clr),
    .busy          (busy),
    .slot_valid    (slot_valid),
    .bank_num      (bank_num),
    .op_num        (op_num),
    .ch_num        (ch_num),
    .op_type       (op_type),
    .sample_done   (sample_done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  wire [14:0] dut_vec = {busy, slot_valid, bank_num, op_num, ch_num, op_type, sample_done, overrun};

  // Expected outputs from position k within a sweep (k = 0 is the first RUN cycle).
  function automatic logic [14:0] model_vec(input bit active, input int k, input bit ovr);
    int  slot, op, bank, ch, typ;
    bit  sv, sd;
    slot = 0; op = 0; bank = 0; sv = 1'b0; sd = 1'b0;
    if (active && k < SWEEP) begin
      slot = k / CPS;
      bank = slot / OPB;
      op   = slot % OPB;
      sv   = (k % CPS) == 0;
    end
    if (active && k == SWEEP) sd = 1'b1;
    ch  = (op % 3) + 3 * (op / 6);
    typ = (op / 3) % 2;
    return {active, sv, 1'(bank), 5'(op), 4'(ch), 1'(typ), sd, ovr};
  endfunction

  // Model update on every edge, then compare all outputs one step later.
  initial begin
    bit m_active, m_ovr, was, r, e, c;
    int m_k;
    logic [14:0] exp_vec;
    m_active = 1'b0; m_ovr = 1'b0; m_k = 0;
    forever begin
      @(posedge clk);
      r = reset; e = sample_clk_en; c = overrun_clr;
      if (r) begin
        m_active = 1'b0; m_k = 0; m_ovr = 1'b0;
      end else begin
        was = m_active;
        if (was) begin
          m_k++;
          if (m_k > SWEEP) m_active = 1'b0;
        end else if (e) begin
          m_active = 1'b1;
          m_k = 0;
        end
        if (OVR_EN != 0) begin
          if (e && was) m_ovr = 1'b1;
          else if (c) m_ovr = 1'b0;
        end
      end
      #1;
      exp_vec = model_vec(m_active, m_k, m_ovr);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, dut_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; sample_clk_en = 1'b0; overrun_clr = 1'b0;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_slot_valid", int'(slot_valid), 0);
    chk("rst_done", int'(sample_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_op", int'(op_num), 0);
    chk("rst_ch", int'(ch_num), 0);
    reset = 1'b0;
    tick();

    // Full sweep with a dropped request at 50 and a clear at 200.
    for (int rel = 0; rel <= 210; rel++) begin
      sample_clk_en = (rel == 0 || rel == 50);
      overrun_clr   = (rel == 200);
      tick();
      case (rel + 1)
        1: begin
          chk("a1_slot_valid", int'(slot_valid), 1);
          chk("a1_op", int'(op_num), 0);
          chk("a1_busy", int'(busy), 1);
        end
        2:   chk("a2_slot_valid", int'(slot_valid), 0);
        5: begin
          chk("a5_slot_valid", int'(slot_valid), 1);
          chk("a5_op", int'(op_num), 1);
        end
        17: begin
          chk("op4_op", int'(op_num), 4);
          chk("op4_ch", int'(ch_num), 1);
          chk("op4_type", int'(op_type), 1);
        end
        25: begin
          chk("op6_op", int'(op_num), 6);
          chk("op6_ch", int'(ch_num), 3);
          chk("op6_type", int'(op_type), 0);
        end
        51: chk("ovr_set", int'(overrun), OVR_EN);
        69: begin
          chk("op17_op", int'(op_num), 17);
          chk("op17_ch", int'(ch_num), 8);
          chk("op17_type", int'(op_type), 1);
        end
        72: chk("bank_before", int'(bank_num), 0);
        73: begin
          chk("bank_switch", int'(bank_num), 1);
          chk("bank_switch_op", int'(op_num), 0);
          chk("bank_switch_sv", int'(slot_valid), 1);
        end
        141: chk("last_slot_sv", int'(slot_valid), 1);
        144: chk("pre_done", int'(sample_done), 0);
        145: begin
          chk("done_pulse", int'(sample_done), 1);
          chk("done_busy", int'(busy), 1);
          chk("done_op", int'(op_num), 0);
        end
        146: begin
          chk("idle_busy", int'(busy), 0);
          chk("idle_done", int'(sample_done), 0);
        end
        201: chk("ovr_clear", int'(overrun), 0);
        default: ;
      endcase
    end

    // Reset mid-sweep, then restart immediately.
    for (int rel = 0; rel <= 210; rel++) begin
      sample_clk_en = (rel == 0 || rel == 61);
      overrun_clr   = 1'b0;
      reset         = (rel == 60);
      tick();
      case (rel + 1)
        61: begin
          chk("abort_busy", int'(busy), 0);
          chk("abort_done", int'(sample_done), 0);
          chk("abort_op", int'(op_num), 0);
          chk("abort_sv", int'(slot_valid), 0);
        end
        62: begin
          chk("restart_sv", int'(slot_valid), 1);
          chk("restart_op", int'(op_num), 0);
          chk("restart_bank", int'(bank_num), 0);
        end
        206: chk("restart_done", int'(sample_done), 1);
        default: ;
      endcase
    end
    reset = 1'b0;

    // Request together with clear in the DONE cycle.
    for (int rel = 0; rel <= 150; rel++) begin
      sample_clk_en = (rel == 0 || rel == 145);
      overrun_clr   = (rel == 145 || rel == 148);
      tick();
      case (rel + 1)
        145: chk("c_done", int'(sample_done), 1);
        146: begin
          chk("c_ovr_set_wins", int'(overrun), OVR_EN);
          chk("c_dropped_busy", int'(busy), 0);
        end
        147: chk("c_no_start", int'(slot_valid), 0);
        149: chk("c_ovr_cleared", int'(overrun), 0);
        default: ;
      endcase
    end
    sample_clk_en = 1'b0;
    overrun_clr   = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
